// File: rtl/tisc_ident_spi_v2.sv
// tisc_ident_spi_v2
//   TISC identification / control WISHBONE slave.
//   Word map (adr_i[5:2]):
//     0 IDENT (RO)        1 VERSION (RO)
//     2 CTRL0 [0]SYSCLK_SEL [1]EN_LOCAL_CLK
//     3 SPI_CS [NUM_CS-1:0], 1 = chip selected (CS_B = ~reg)
//     4 SPI_DIV [15:0], SCK half-period = DIV+1 clk cycles
//     5 SPI_DATA  write: TX byte, starts a transfer; read: last RX byte
//     6 SPI_STAT [0]BUSY [1]DONE [2]OVR (write 1 to bit1/bit2 clears)
//     7 UPTIME free-running clk counter
//     8-15 read as 0, writes ignored
// Ports
//   clk_i, rst_n_i            clock, synchronous active-low reset
//   cyc_i/stb_i/we_i/adr_i/sel_i/dat_i/dat_o/ack_o/err_o/rty_o  WISHBONE slave
//   SYSCLK_SEL, EN_LOCAL_CLK  board clock control
//   CS_B, SCK, MOSI, MISO     SPI master, mode 0, MSB first
module tisc_ident_spi_v2 #(
    parameter logic [31:0] IDENT         = 32'h54534332,
    parameter logic [31:0] VERSION       = 32'h00000000,
    parameter int          NUM_CS        = 1,
    parameter logic [15:0] DIV_DEFAULT   = 16'd3,
    parameter logic [1:0]  CTRL0_DEFAULT = 2'b11
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [5:0]        adr_i,
    input  logic [3:0]        sel_i,
    input  logic [31:0]       dat_i,
    output logic [31:0]       dat_o,
    output logic              ack_o,
    output logic              err_o,
    output logic              rty_o,
    output logic              SYSCLK_SEL,
    output logic              EN_LOCAL_CLK,
    output logic [NUM_CS-1:0] CS_B,
    output logic              SCK,
    output logic              MOSI,
    input  logic              MISO
);

    typedef enum logic {S_IDLE, S_SHIFT} spi_state_t;

    spi_state_t        r_state, w_next;
    logic              r_ack;
    logic [31:0]       r_dat;
    logic [1:0]        r_ctrl0;
    logic [NUM_CS-1:0] r_cs;
    logic [15:0]       r_div, r_cnt;
    logic [7:0]        r_tx, r_rx;
    logic [3:0]        r_tog;
    logic              r_sck, r_mosi, r_done, r_ovr;
    logic [31:0]       r_uptime;

    logic        w_acc, w_wr, w_busy, w_start, w_last;
    logic [3:0]  w_word;
    logic [31:0] w_rdata;
    logic        w_unused;

    // Handshake: a new access is accepted only while ack is low, so each
    // strobe produces exactly one single-cycle ack and one side effect.
    assign w_acc   = cyc_i & stb_i & ~r_ack;
    assign w_wr    = w_acc & we_i;
    assign w_word  = adr_i[5:2];
    assign w_busy  = (r_state == S_SHIFT);
    assign w_start = w_wr && (w_word == 4'd5) && !w_busy;
    // Last event of a transfer: 16th SCK toggle, which is a falling edge.
    assign w_last  = w_busy && (r_cnt == 16'd0) && r_sck && (r_tog == 4'd15);

    assign w_unused = ^{sel_i, adr_i[1:0], dat_i};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_SHIFT;
            S_SHIFT: if (w_last)  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = 32'd0;
        case (w_word)
            4'd0: w_rdata = IDENT;
            4'd1: w_rdata = VERSION;
            4'd2: w_rdata = {30'd0, r_ctrl0};
            4'd3: w_rdata = {{(32-NUM_CS){1'b0}}, r_cs};
            4'd4: w_rdata = {16'd0, r_div};
            4'd5: w_rdata = {24'd0, r_rx};
            4'd6: w_rdata = {29'd0, r_ovr, r_done, w_busy};
            4'd7: w_rdata = r_uptime;
            default: w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_ack    <= 1'b0;
            r_dat    <= 32'd0;
            r_ctrl0  <= CTRL0_DEFAULT;
            r_cs     <= '0;
            r_div    <= DIV_DEFAULT;
            r_cnt    <= 16'd0;
            r_tx     <= 8'd0;
            r_rx     <= 8'd0;
            r_tog    <= 4'd0;
            r_sck    <= 1'b0;
            r_mosi   <= 1'b0;
            r_done   <= 1'b0;
            r_ovr    <= 1'b0;
            r_uptime <= 32'd0;
        end else begin
            r_uptime <= r_uptime + 32'd1;
            r_ack    <= w_acc;
            r_dat    <= w_acc ? w_rdata : 32'd0;

            if (w_wr) begin
                case (w_word)
                    4'd2: r_ctrl0 <= dat_i[1:0];
                    4'd3: if (!w_busy) r_cs <= dat_i[NUM_CS-1:0];
                    4'd4: if (!w_busy) r_div <= dat_i[15:0];
                    4'd5: if (w_busy) r_ovr <= 1'b1;
                    4'd6: begin
                        if (dat_i[1]) r_done <= 1'b0;
                        if (dat_i[2]) r_ovr  <= 1'b0;
                    end
                    default: ;
                endcase
            end

            // SPI datapath; completion is assigned after the STAT clear so
            // a simultaneous set wins.
            if (w_start) begin
                r_tx   <= dat_i[7:0];
                r_mosi <= dat_i[7];
                r_cnt  <= r_div;
                r_tog  <= 4'd0;
                r_done <= 1'b0;
            end else if (w_busy) begin
                if (r_cnt == 16'd0) begin
                    r_cnt <= r_div;
                    r_sck <= ~r_sck;
                    r_tog <= r_tog + 4'd1;
                    if (!r_sck) begin
                        r_rx <= {r_rx[6:0], MISO};
                    end else begin
                        // Next bit is tx[6] before the shift; zeros fill in
                        // so MOSI settles low after the last bit.
                        r_tx   <= {r_tx[6:0], 1'b0};
                        r_mosi <= r_tx[6];
                        if (r_tog == 4'd15) r_done <= 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt - 16'd1;
                end
            end
        end
    end

    assign dat_o        = r_dat;
    assign ack_o        = r_ack;
    assign err_o        = 1'b0;
    assign rty_o        = 1'b0;
    assign SYSCLK_SEL   = r_ctrl0[0];
    assign EN_LOCAL_CLK = r_ctrl0[1];
    assign CS_B         = ~r_cs;
    assign SCK          = r_sck;
    assign MOSI         = r_mosi;

endmodule
